// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target.
// Optional clock stretching is selected in i2c_target with I2C_TARGET_STRETCH_EN.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync.sv
// Synchronises SCL/SDA into clk and flags SCL edges and START/STOP conditions.
// Detection is held off after reset until the reset-high flops have flushed.
module i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [SYNC_STAGES:0]   settle;
    logic                   scl_s;
    logic                   live;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            settle   <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // A bus that sits low at reset release would otherwise look like a fresh edge.
    assign live = settle[SYNC_STAGES];

    assign scl_rise  = live &  scl_s & ~scl_d;
    assign scl_fall  = live & ~scl_s &  scl_d;
    assign start_det = live &  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  = live &  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit addressed byte writes to rx_data and byte reads from tx_data.
// Define I2C_TARGET_STRETCH_EN to hold SCL low while tx_data is not yet valid.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       addressed
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t state;
    logic [3:0]     bit_cnt;
    logic [6:0]     shreg;
    logic [6:0]     tx_shift;
    logic           rw;
    logic           ack_on;
    logic           mack;
    logic [7:0]     rx_byte;
    logic           tx_begin;

    assign rx_byte = {shreg, sda_s};

    // The SCL fall that opens a read byte: end of the address ACK, or after a master ACK.
    assign tx_begin = scl_fall &
                      (((state == ST_ADDR_ACK) & ack_on & rw) |
                       ((state == ST_TX_ACK) & mack));

`ifdef I2C_TARGET_STRETCH_EN
    logic stretch;
    logic scl_rel;
`else
    assign scl_oe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        tx_ready <= 1'b0;
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            mack      <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            busy      <= 1'b0;
            addressed <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_oe    <= 1'b0;
            stretch   <= 1'b0;
            scl_rel   <= 1'b0;
`endif
        end else if (start_det) begin
            state     <= ST_ADDR;
            bit_cnt   <= 4'd0;
            ack_on    <= 1'b0;
            mack      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
            addressed <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_oe    <= 1'b0;
            stretch   <= 1'b0;
            scl_rel   <= 1'b0;
`endif
        end else if (stop_det) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            ack_on    <= 1'b0;
            mack      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_oe    <= 1'b0;
            stretch   <= 1'b0;
            scl_rel   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg <= rx_byte[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            rw      <= rx_byte[0];
                            if (rx_byte[7:1] == ADDR) begin
                                state     <= ST_ADDR_ACK;
                                addressed <= 1'b1;
                                ack_on    <= 1'b0;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    // First fall starts the ACK slot, second fall ends it.
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= ~I2C_ACK;
                            ack_on <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            ack_on <= 1'b0;
                            state  <= (state == ST_ADDR_ACK && rw) ? ST_TX : ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shreg <= rx_byte[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= 4'd0;
                            rx_data  <= rx_byte;
                            rx_valid <= 1'b1;
                            ack_on   <= 1'b0;
                            state    <= ST_RX_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        mack    <= 1'b0;
                        state   <= ST_TX_ACK;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        sda_oe   <= ~tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b1};
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state <= ST_WAIT_STOP;
                        end else begin
                            mack <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (tx_begin) begin
                state   <= ST_TX;
                bit_cnt <= 4'd0;
                mack    <= 1'b0;
                if (tx_valid) begin
                    tx_shift <= tx_data[6:0];
                    tx_ready <= 1'b1;
                    sda_oe   <= ~tx_data[7];
                end else begin
`ifdef I2C_TARGET_STRETCH_EN
                    stretch <= 1'b1;
                    scl_oe  <= 1'b1;
                    sda_oe  <= 1'b0;
`else
                    tx_shift <= 7'h7F;
                    sda_oe   <= 1'b0;
`endif
                end
            end

`ifdef I2C_TARGET_STRETCH_EN
            // SCL is let go one clk after the first bit is on SDA, so setup is met.
            if (stretch && tx_valid) begin
                tx_shift <= tx_data[6:0];
                tx_ready <= 1'b1;
                sda_oe   <= ~tx_data[7];
                stretch  <= 1'b0;
                scl_rel  <= 1'b1;
            end
            if (scl_rel) begin
                scl_oe  <= 1'b0;
                scl_rel <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42: the 7-bit target address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on scl_i/sda_i, legal range 2..4.
REQ-003 SHALL have ports: clk in 1, system clock; rst in 1, reset (one clock; reset is synchronous and active-high).
REQ-004 SHALL have ports: scl_i in 1, bus SCL level; sda_i in 1, bus SDA level.
REQ-005 SHALL have ports: scl_oe out 1, 1 pulls SCL low; sda_oe out 1, 1 pulls SDA low (open-drain; pad never drives high).
REQ-006 SHALL have ports: rx_data out 8, last byte written by the master; rx_valid out 1, one-clk pulse when rx_data is new.
REQ-007 SHALL have ports: tx_data in 8, byte to return on a read; tx_valid in 1, tx_data available; tx_ready out 1, one-clk pulse when tx_data is consumed.
REQ-008 SHALL have ports: busy out 1, high from START to STOP; addressed out 1, high while this target is selected.

Function
REQ-009 SHALL pass scl_i/sda_i through SYNC_STAGES flops, then one history flop for edge detection; all decisions use synced values.
REQ-010 SHALL detect START as synced SDA falling while SCL high, and STOP as synced SDA rising while SCL high.
REQ-011 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-012 SHALL sample SDA on each synced SCL rising edge and change sda_oe only on synced SCL falling edges.
REQ-013 ADDR: SHALL shift 7 address bits plus R/W MSB-first; on 8th rise, match -> ADDR_ACK, mismatch -> WAIT_STOP.
REQ-014 ADDR_ACK: SHALL assert sda_oe from the next SCL fall to the following SCL fall, set addressed, then enter RX (R/W=0) or TX (R/W=1).
REQ-015 RX: SHALL shift 8 bits; on the 8th rise, SHALL update rx_data and pulse rx_valid for one clk, then ACK as in REQ-014 and return to RX.
REQ-016 TX: on the SCL fall that starts each byte, SHALL latch tx_data, pulse tx_ready, and drive sda_oe = ~bit MSB-first, each bit changing on an SCL fall.
REQ-017 TX: if tx_valid is low at latch time, SHALL send 8'hFF (SDA released) and SHALL NOT pulse tx_ready.
REQ-018 TX_ACK: SHALL release SDA and sample the master's bit on the 9th rise; ACK (0) -> TX, NACK (1) -> WAIT_STOP.
REQ-019 WAIT_STOP: SHALL keep sda_oe=0 and ignore data bits until STOP or START.
REQ-020 SHALL treat START in any state (including repeated START) as: release SDA, clear addressed, reset the bit counter, enter ADDR.
REQ-021 SHALL treat STOP in any state as: release both lines, clear addressed and busy, enter IDLE.
REQ-022 If START/STOP and an SCL edge coincide in one clk, START/STOP SHALL take priority.
REQ-023 SHALL use a 4-bit bit counter 0..8 that clears on every START/STOP and byte boundary and never wraps.

Reset
REQ-024 rst high at a clk rising edge SHALL force: state IDLE, scl_oe=0, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, busy=0, addressed=0, synchronizer flops=1.
REQ-025 Reset mid-transfer SHALL release the bus immediately; after reset the block SHALL stay in IDLE until the next START, ignoring the rest of the in-flight transfer.

Configuration
REQ-026 With macro I2C_TARGET_STRETCH_EN defined: in TX, if tx_valid is low at latch time, SHALL hold scl_oe=1 until tx_valid is high, then latch, pulse tx_ready, and release SCL one clk after driving the first bit.
REQ-027 With I2C_TARGET_STRETCH_EN defined: STOP or START SHALL release any stretch; scl_oe SHALL never assert outside TX.
REQ-028 Without I2C_TARGET_STRETCH_EN: scl_oe SHALL be tied to 0 and REQ-017 applies.

Structure
REQ-029 Package i2c_pkg SHALL hold the state enum i2c_tgt_state_t and the constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
REQ-030 Sub-module i2c_sync SHALL implement the synchronizer and edge/START/STOP detection, with outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Verification
REQ-031 Write 0x84 (addr 0x42, W), data 0xA5, STOP -> ACK after the address, rx_valid pulse with rx_data=0xA5, ACK, busy falls at STOP.
REQ-032 Address 0x43 W, data 0x11 -> no ACK, no rx_valid, addressed stays 0, sda_oe stays 0.
REQ-033 Read 0x85 with tx_data=0x3C then 0xC3, master ACKs then NACKs -> bus carries 0x3C then 0xC3, two tx_ready pulses, then WAIT_STOP.
REQ-034 Write 0x84, 0x55, repeated START, 0x85, read one byte -> rx_data=0x55, then TX entered, with no STOP between the two transfers.
REQ-035 Read with tx_valid=0 for 50 SCL-low clocks -> 0xFF sent without the stretch macro; with I2C_TARGET_STRETCH_EN, scl_oe held for that time, then tx_data sent.
REQ-036 rst asserted during the 4th data bit of a write -> all outputs go to reset values the next clk, and there is no rx_valid until a new START.
